fft_config_sequencer: RTL
=========================

Name: fft_config_sequencer

Overview:
- Sequences the AXI-Stream configuration channels of the forward FFT core and the inverse IFFT core from one frameSize setting.
- Issues the forward word first, then the inverse word, then waits a settle interval before reporting the datapath as configured.
- Reconfiguration starts only while the frame datapath is idle between frames. Sits between the user frame-size control and both transform cores.

Parameters:
- MIN_LOG2, 3, smallest legal log2 transform length
- MAX_LOG2, 12, largest legal log2 transform length
- SCALE_SCH, 14'h2AAA, scaling schedule placed in both config words
- SETTLE_CYCLES, 4, cycles to wait after the inverse handshake before cfgDone; must be at least 1

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- frameSize  in  4  requested log2 transform length
- frameIdle  in  1  high when no frame is in flight in the FFT/IFFT datapath
- fwdTData  out  24  forward-core config word
- fwdTValid  out  1  forward config valid
- fwdTReady  in  1  forward config ready
- invTData  out  24  inverse-core config word
- invTValid  out  1  inverse config valid
- invTReady  in  1  inverse config ready
- cfgDone  out  1  both cores configured with the current size (level)
- cfgBusy  out  1  reconfiguration in progress; the datapath must not start a frame
- sizeErr  out  1  one-cycle pulse when the requested size is clamped

Behaviour:
- Clock and reset: single clock CLK. RST_N is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, appliedSize = MIN_LOG2, pending = 1. The first configuration runs automatically after reset release.
- Config word layout: [4:0] = effective log2 size; [7:5] = 0; [8] = FWD_INV (1 on fwd, 0 on inv); [22:9] = SCALE_SCH; [23] = 0.
- Clamping:
  - effSize = frameSize clamped to [MIN_LOG2, MAX_LOG2].
  - sizeErr pulses for one cycle when a new out-of-range value first differs from the previous registered frameSize sample.
- Change detection:
  - pending is set on any cycle where effSize != appliedSize.
  - pending is cleared when SEND_FWD is entered.
  - targetSize latches effSize on entry to SEND_FWD and is held stable for both words.
- States:
  - IDLE: cfgBusy = 0. Go to SEND_FWD when pending && frameIdle.
  - SEND_FWD: fwdTValid = 1, fwdTData built from targetSize. On fwdTValid && fwdTReady, go to SEND_INV.
  - SEND_INV: invTValid = 1. On handshake, load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement the counter. At 0, set appliedSize = targetSize and go to DONE.
  - DONE: cfgDone = 1. If pending && frameIdle, go to SEND_FWD (cfgDone drops the same cycle the state leaves DONE). Otherwise stay in DONE.
- Output timing: cfgBusy = 1 in SEND_FWD, SEND_INV and SETTLE. cfgDone is low in every state except DONE.
- Latency (both readies high): entry to SEND_FWD → fwd handshake in cycle 0 → inv handshake in cycle 1 → cfgDone high at cycle 2 + SETTLE_CYCLES.
- AXI rules:
  - Valid stays asserted and data stays stable until ready is seen; valid never depends combinationally on ready.
  - At most one valid is high at any time.
- Size change mid-sequence: the current sequence completes with the old targetSize. pending is then set, so a new sequence follows as soon as frameIdle allows.
- frameIdle low while pending: hold in IDLE/DONE with no config issued. cfgDone stays high in DONE, reflecting the old size.
- Reset mid-handshake: outputs clear immediately (asynchronously) and the sequence restarts after release.
- Ready high while valid is low: ignored.

Decomposition:
- Shared package fft_cfg_pkg:
  - state enum
  - field offsets/widths of the config word
  - FWD/INV bit constants
  - function pack_cfg(size, fwdInv, scale)
- One natural sub-module, axis_cfg_slot: a one-entry valid/ready holding register, instantiated once per channel.

Test Plan:
- Reset release, frameIdle = 1, both readies = 1, frameSize = 10 → fwdTData = 24'h55550A, then invTData = 24'h55540A on the next cycle. cfgDone rises 6 cycles after the fwd handshake. cfgBusy high throughout the sequence.
- fwdTReady held 0 for 5 cycles → fwdTValid stays high with fwdTData stable. invTValid stays 0 until the cycle after the fwd handshake.
- frameSize = 15 (MAX_LOG2 = 12) → sizeErr pulses exactly once; both config words carry size field 12.
- In DONE, frameSize changes 10→8 with frameIdle = 0 for 20 cycles → no valid asserted, cfgDone stays 1. frameIdle rises → new sequence with size 8.
- frameSize changes 8→9 during SEND_INV → the sequence finishes with 8, then a second sequence with 9 follows. Final appliedSize = 9, cfgDone = 1.
- RST_N asserted during SETTLE → all outputs 0 in the same cycle. After release, a full sequence repeats.

Source files
------------

// File: rtl/fft_cfg_pkg.sv
// Shared definitions for the FFT/IFFT configuration sequencer: FSM states,
// config word field layout and the word packing helper.
package fft_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_FWD,
        SEND_INV,
        SETTLE,
        DONE
    } cfgState_t;

    // Config word layout: [4:0] size, [7:5] zero, [8] direction,
    // [22:9] scaling schedule, [23] zero.
    localparam int CFG_W      = 24;
    localparam int SIZE_LSB   = 0;
    localparam int SIZE_W     = 5;
    localparam int FWDINV_BIT = 8;
    localparam int SCALE_LSB  = 9;
    localparam int SCALE_W    = 14;

    // Direction bit values carried in the FWD_INV field.
    localparam logic CFG_FWD = 1'b1;
    localparam logic CFG_INV = 1'b0;

    // Channel indices of the two config slots.
    localparam int FWD_CH = 0;
    localparam int INV_CH = 1;

    // Builds a config word; unused fields stay zero.
    function automatic logic [CFG_W-1:0] pack_cfg(
        input logic [SIZE_W-1:0]  size,
        input logic               fwdInv,
        input logic [SCALE_W-1:0] scale
    );
        logic [CFG_W-1:0] word;
        word = '0;
        word[SIZE_LSB +: SIZE_W]   = size;
        word[FWDINV_BIT]           = fwdInv;
        word[SCALE_LSB +: SCALE_W] = scale;
        return word;
    endfunction

endpackage

// File: rtl/axis_cfg_slot.sv
// One-entry AXI-Stream holding register: a load pulse captures a word and
// raises valid; valid drops on the handshake. Data is held between loads.
module axis_cfg_slot #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         load,
    input  logic [W-1:0] loadData,
    output logic         tValid,
    output logic [W-1:0] tData,
    input  logic         tReady
);

    // Load takes priority; otherwise the word is retired on handshake.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tValid <= 1'b0;
            tData  <= '0;
        end else if (load) begin
            tValid <= 1'b1;
            tData  <= loadData;
        end else if (tValid && tReady) begin
            tValid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_config_sequencer.sv
// Sequences forward then inverse transform config words from one frame-size
// control, waits a settle interval and then reports the datapath configured.
module fft_config_sequencer
    import fft_cfg_pkg::*;
#(
    parameter int                 MIN_LOG2      = 3,
    parameter int                 MAX_LOG2      = 12,
    parameter logic [SCALE_W-1:0] SCALE_SCH     = 14'h2AAA,
    parameter int                 SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       frameSize,
    input  logic             frameIdle,
    output logic [CFG_W-1:0] fwdTData,
    output logic             fwdTValid,
    input  logic             fwdTReady,
    output logic [CFG_W-1:0] invTData,
    output logic             invTValid,
    input  logic             invTReady,
    output logic             cfgDone,
    output logic             cfgBusy,
    output logic             sizeErr
);

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [3:0]       MIN_REQ     = 4'(MIN_LOG2);
    localparam logic [3:0]       MAX_REQ     = 4'(MAX_LOG2);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    cfgState_t         state;
    logic [SIZE_W-1:0] effSize;
    logic [SIZE_W-1:0] targetSize;
    logic [SIZE_W-1:0] appliedSize;
    logic [SIZE_W-1:0] refSize;
    logic [3:0]        prevSize;
    logic              pending;
    logic              outOfRange;
    logic              startSeq;
    logic [CNT_W-1:0]  settleCnt;

    logic [1:0]        slotLoad;
    logic [1:0]        slotValid;
    logic [1:0]        slotReady;
    logic [CFG_W-1:0]  slotLoadData [2];
    logic [CFG_W-1:0]  slotData     [2];

    // Clamp the request, pick the comparison reference and drive slot loads.
    // While a sequence is in flight its target is the reference, so the
    // size already being applied does not re-arm pending.
    always_comb begin
        outOfRange = (frameSize < MIN_REQ) || (frameSize > MAX_REQ);
        if (frameSize < MIN_REQ) begin
            effSize = SIZE_W'(MIN_LOG2);
        end else if (frameSize > MAX_REQ) begin
            effSize = SIZE_W'(MAX_LOG2);
        end else begin
            effSize = SIZE_W'(frameSize);
        end
        refSize  = ((state == IDLE) || (state == DONE)) ? appliedSize : targetSize;
        startSeq = pending && frameIdle && ((state == IDLE) || (state == DONE));

        slotLoad[FWD_CH]     = startSeq;
        slotLoadData[FWD_CH] = pack_cfg(effSize, CFG_FWD, SCALE_SCH);
        slotLoad[INV_CH]     = (state == SEND_FWD) && fwdTValid && fwdTReady;
        slotLoadData[INV_CH] = pack_cfg(targetSize, CFG_INV, SCALE_SCH);
    end

    assign slotReady = {invTReady, fwdTReady};

    for (genvar gi = 0; gi < 2; gi++) begin : gSlot
        axis_cfg_slot #(
            .W(CFG_W)
        ) uSlot (
            .clk      (CLK),
            .rstN     (RST_N),
            .load     (slotLoad[gi]),
            .loadData (slotLoadData[gi]),
            .tValid   (slotValid[gi]),
            .tData    (slotData[gi]),
            .tReady   (slotReady[gi])
        );
    end

    assign fwdTValid = slotValid[FWD_CH];
    assign fwdTData  = slotData[FWD_CH];
    assign invTValid = slotValid[INV_CH];
    assign invTData  = slotData[INV_CH];

    // Sequencer FSM with registered status outputs and change tracking.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            targetSize  <= SIZE_W'(MIN_LOG2);
            appliedSize <= SIZE_W'(MIN_LOG2);
            prevSize    <= MIN_REQ;
            pending     <= 1'b1;
            settleCnt   <= '0;
            cfgBusy     <= 1'b0;
            cfgDone     <= 1'b0;
            sizeErr     <= 1'b0;
        end else begin
            prevSize <= frameSize;
            sizeErr  <= outOfRange && (frameSize != prevSize);

            if (startSeq) begin
                pending <= 1'b0;
            end else if (effSize != refSize) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (startSeq) begin
                        state      <= SEND_FWD;
                        targetSize <= effSize;
                        cfgBusy    <= 1'b1;
                        cfgDone    <= 1'b0;
                    end
                end
                SEND_FWD: begin
                    if (fwdTValid && fwdTReady) begin
                        state <= SEND_INV;
                    end
                end
                SEND_INV: begin
                    if (invTValid && invTReady) begin
                        settleCnt <= SETTLE_LOAD;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settleCnt == '0) begin
                        appliedSize <= targetSize;
                        state       <= DONE;
                        cfgBusy     <= 1'b0;
                        cfgDone     <= 1'b1;
                    end else begin
                        settleCnt <= settleCnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cfgBusy <= 1'b0;
                    cfgDone <= 1'b0;
                end
            endcase
        end
    end

endmodule
